// File: rtl/axilite_reg_arb_pkg.sv
// Shared types and helpers for the register-interface round-robin arbiter.
//   state_e    : per-channel FSM state (IDLE -> BUSY -> ACK)
//   tmo_width  : timeout counter width for a given TIMEOUT (min 1 bit)
//   rr_next    : round-robin grant search starting just after the pointer
package axilite_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Upper bound on requesters the grant search handles.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_REQ_W = 5;

    // Counter must hold 0..TIMEOUT; keep at least one bit when disabled.
    function automatic int unsigned tmo_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

    // First set request above ptr, wrapping at n; returns ptr if none set.
    function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] req,
                                            input int unsigned       ptr,
                                            input int unsigned       n);
        logic [MAX_REQ_W-1:0] idx;
        int unsigned          sel;
        logic                 found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = MAX_REQ_W'((ptr + i) % n);
            if (!found && (i <= n) && req[idx]) begin
                sel   = 32'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axilite_reg_arb_chan.sv
// Single-channel round-robin arbiter: grants one of N_REQ requesters,
// registers its command towards the target, and returns a one-cycle ack
// (plus optional return data) to the granted requester.
// Ports:
//   s_en/s_cmd   : per-requester request and packed command
//   s_wait       : target wait, forwarded to the granted requester only
//   s_ack/s_ret  : one-cycle completion and return data (0 outside the ack)
//   m_cmd/m_en   : registered target command and enable
//   m_wait/m_ack : target wait (suspends timeout) and completion
//   m_ret        : target return data, sampled on m_ack
module axilite_reg_arb_chan
    import axilite_reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned CMD_WIDTH = 32,
    parameter int unsigned RET_WIDTH = 1,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             s_en,
    input  logic [N_REQ*CMD_WIDTH-1:0]   s_cmd,
    output logic [N_REQ-1:0]             s_wait,
    output logic [N_REQ-1:0]             s_ack,
    output logic [RET_WIDTH-1:0]         s_ret,
    output logic [CMD_WIDTH-1:0]         m_cmd,
    output logic                         m_en,
    input  logic                         m_wait,
    input  logic                         m_ack,
    input  logic [RET_WIDTH-1:0]         m_ret
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = tmo_width(TIMEOUT);

    state_e                state, state_d;
    logic [IW-1:0]         gnt, gnt_d;
    logic [IW-1:0]         ptr, ptr_d;
    logic [CMD_WIDTH-1:0]  cmd_d;
    logic                  en_d;
    logic [N_REQ-1:0]      ack_d;
    logic [RET_WIDTH-1:0]  ret_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [CMD_WIDTH-1:0]  cmd_arr [N_REQ];

    // Unpack the requester commands for indexed selection.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign cmd_arr[i] = s_cmd[i*CMD_WIDTH +: CMD_WIDTH];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= IW'(N_REQ - 1);
            m_cmd <= '0;
            m_en  <= 1'b0;
            s_ack <= '0;
            s_ret <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            ptr   <= ptr_d;
            m_cmd <= cmd_d;
            m_en  <= en_d;
            s_ack <= ack_d;
            s_ret <= ret_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        ptr_d   = ptr;
        cmd_d   = m_cmd;
        en_d    = m_en;
        ack_d   = '0;
        ret_d   = '0;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (|s_en) begin
                    gnt_d   = IW'(rr_next(MAX_REQ'(s_en), 32'(ptr), N_REQ));
                    ptr_d   = gnt_d;
                    cmd_d   = cmd_arr[gnt_d];
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (m_ack) begin
                    en_d       = 1'b0;
                    ret_d      = m_ret;
                    ack_d[gnt] = 1'b1;
                    state_d    = ACK;
                end else if ((TIMEOUT != 0) && !m_wait) begin
                    // Self-ack with zero data once TIMEOUT non-wait cycles pass.
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        en_d       = 1'b0;
                        ack_d[gnt] = 1'b1;
                        state_d    = ACK;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Target wait goes straight through to the granted requester.
    always_comb begin
        s_wait = '0;
        if (state == BUSY) begin
            s_wait[gnt] = m_wait;
        end
    end

endmodule

// File: rtl/axilite_reg_arb.sv
// Round-robin arbiter sharing one register-interface target between N_REQ
// requesters; write and read channels are arbitrated independently, each
// with one registered stage per direction and an optional timeout.
// Ports:
//   s_wr_* / s_rd_* : packed requester-side write and read interfaces
//   m_wr_* / m_rd_* : single target-side write and read interfaces
module axilite_reg_arb
    import axilite_reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned DATA_WR_WIDTH = 32,
    parameter int unsigned DATA_RD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH    = 40,
    parameter int unsigned STRB_WIDTH    = 4,
    parameter int unsigned TIMEOUT       = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    s_wr_addr,
    input  logic [N_REQ*DATA_WR_WIDTH-1:0] s_wr_data,
    input  logic [N_REQ*STRB_WIDTH-1:0]    s_wr_strb,
    input  logic [N_REQ-1:0]               s_wr_en,
    output logic [N_REQ-1:0]               s_wr_wait,
    output logic [N_REQ-1:0]               s_wr_ack,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    s_rd_addr,
    input  logic [N_REQ-1:0]               s_rd_en,
    output logic [DATA_RD_WIDTH-1:0]       s_rd_data,
    output logic [N_REQ-1:0]               s_rd_wait,
    output logic [N_REQ-1:0]               s_rd_ack,
    output logic [ADDR_WIDTH-1:0]          m_wr_addr,
    output logic [DATA_WR_WIDTH-1:0]       m_wr_data,
    output logic [STRB_WIDTH-1:0]          m_wr_strb,
    output logic                           m_wr_en,
    input  logic                           m_wr_wait,
    input  logic                           m_wr_ack,
    output logic [ADDR_WIDTH-1:0]          m_rd_addr,
    output logic                           m_rd_en,
    input  logic [DATA_RD_WIDTH-1:0]       m_rd_data,
    input  logic                           m_rd_wait,
    input  logic                           m_rd_ack
);

    localparam int unsigned WCMD_W = ADDR_WIDTH + DATA_WR_WIDTH + STRB_WIDTH;

    logic [N_REQ*WCMD_W-1:0] wr_cmd;
    logic [WCMD_W-1:0]       wr_m_cmd;
    logic                    wr_ret_unused;

    // Bundle each requester's write fields into one command word.
    for (genvar i = 0; i < N_REQ; i++) begin : g_wr_pack
        assign wr_cmd[i*WCMD_W +: WCMD_W] = {s_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                             s_wr_data[i*DATA_WR_WIDTH +: DATA_WR_WIDTH],
                                             s_wr_strb[i*STRB_WIDTH +: STRB_WIDTH]};
    end

    assign {m_wr_addr, m_wr_data, m_wr_strb} = wr_m_cmd;

    // Write channel: no return data.
    axilite_reg_arb_chan #(
        .N_REQ     (N_REQ),
        .CMD_WIDTH (WCMD_W),
        .RET_WIDTH (1),
        .TIMEOUT   (TIMEOUT)
    ) u_wr (
        .clk    (clk),
        .rstn   (rstn),
        .s_en   (s_wr_en),
        .s_cmd  (wr_cmd),
        .s_wait (s_wr_wait),
        .s_ack  (s_wr_ack),
        .s_ret  (wr_ret_unused),
        .m_cmd  (wr_m_cmd),
        .m_en   (m_wr_en),
        .m_wait (m_wr_wait),
        .m_ack  (m_wr_ack),
        .m_ret  (1'b0)
    );

    // Read channel: address out, read data back.
    axilite_reg_arb_chan #(
        .N_REQ     (N_REQ),
        .CMD_WIDTH (ADDR_WIDTH),
        .RET_WIDTH (DATA_RD_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_rd (
        .clk    (clk),
        .rstn   (rstn),
        .s_en   (s_rd_en),
        .s_cmd  (s_rd_addr),
        .s_wait (s_rd_wait),
        .s_ack  (s_rd_ack),
        .s_ret  (s_rd_data),
        .m_cmd  (m_rd_addr),
        .m_en   (m_rd_en),
        .m_wait (m_rd_wait),
        .m_ack  (m_rd_ack),
        .m_ret  (m_rd_data)
    );

endmodule

// File: tb/tb_axilite_reg_arb.sv
// Directed self-checking bench for axilite_reg_arb (2 requesters, TIMEOUT=8).
module tb_axilite_reg_arb;

    localparam int unsigned N   = 2;
    localparam int unsigned AW  = 40;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N*AW-1:0]   s_wr_addr;
    logic [N*DW-1:0]   s_wr_data;
    logic [N*SW-1:0]   s_wr_strb;
    logic [N-1:0]      s_wr_en;
    logic [N-1:0]      s_wr_wait;
    logic [N-1:0]      s_wr_ack;
    logic [N*AW-1:0]   s_rd_addr;
    logic [N-1:0]      s_rd_en;
    logic [DW-1:0]     s_rd_data;
    logic [N-1:0]      s_rd_wait;
    logic [N-1:0]      s_rd_ack;
    logic [AW-1:0]     m_wr_addr;
    logic [DW-1:0]     m_wr_data;
    logic [SW-1:0]     m_wr_strb;
    logic              m_wr_en;
    logic              m_wr_wait;
    logic              m_wr_ack;
    logic [AW-1:0]     m_rd_addr;
    logic              m_rd_en;
    logic [DW-1:0]     m_rd_data;
    logic              m_rd_wait;
    logic              m_rd_ack;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    axilite_reg_arb #(
        .N_REQ(N), .DATA_WR_WIDTH(DW), .DATA_RD_WIDTH(DW),
        .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb),
        .s_wr_en(s_wr_en), .s_wr_wait(s_wr_wait), .s_wr_ack(s_wr_ack),
        .s_rd_addr(s_rd_addr), .s_rd_en(s_rd_en), .s_rd_data(s_rd_data),
        .s_rd_wait(s_rd_wait), .s_rd_ack(s_rd_ack),
        .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb),
        .m_wr_en(m_wr_en), .m_wr_wait(m_wr_wait), .m_wr_ack(m_wr_ack),
        .m_rd_addr(m_rd_addr), .m_rd_en(m_rd_en), .m_rd_data(m_rd_data),
        .m_rd_wait(m_rd_wait), .m_rd_ack(m_rd_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr_en(output bit ok);
        int n = 0;
        while (!m_wr_en && n < 10) begin tick(); n++; end
        ok = m_wr_en;
    endtask

    task automatic wait_rd_en(output bit ok);
        int n = 0;
        while (!m_rd_en && n < 10) begin tick(); n++; end
        ok = m_rd_en;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0; s_wr_en = '0;
        s_rd_addr = '0; s_rd_en = '0;
        m_wr_wait = 1'b0; m_wr_ack = 1'b0;
        m_rd_data = '0; m_rd_wait = 1'b0; m_rd_ack = 1'b0;
        tick(); tick();
        checks++;
        if ({m_wr_en, m_rd_en} !== 2'b00) begin
            errors++; $display("FAIL reset_en: got %b want 00", {m_wr_en, m_rd_en});
        end
        checks++;
        if ({s_wr_ack, s_rd_ack, s_wr_wait, s_rd_wait} !== 8'h00) begin
            errors++; $display("FAIL reset_ack_wait: got %h want 00", {s_wr_ack, s_rd_ack, s_wr_wait, s_rd_wait});
        end
        checks++;
        if (m_wr_addr !== '0 || m_wr_data !== '0 || m_wr_strb !== '0 || m_rd_addr !== '0 || s_rd_data !== '0) begin
            errors++; $display("FAIL reset_data: got wa=%h wd=%h ws=%h ra=%h rd=%h want all 0",
                               m_wr_addr, m_wr_data, m_wr_strb, m_rd_addr, s_rd_data);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if ({m_wr_en, m_rd_en} !== 2'b00) begin
            errors++; $display("FAIL reset_release_en: got %b want 00", {m_wr_en, m_rd_en});
        end
    endtask

    task automatic test_single_write();
        s_wr_addr[0 +: AW] = 40'h10;
        s_wr_data[0 +: DW] = 32'hDEADBEEF;
        s_wr_strb[0 +: SW] = 4'hF;
        s_wr_en   = 2'b01;
        m_wr_wait = 1'b1;
        tick();
        checks++;
        if (m_wr_en !== 1'b1) begin
            errors++; $display("FAIL wr_en_latency: got %b want 1", m_wr_en);
        end
        checks++;
        if (m_wr_addr !== 40'h10 || m_wr_data !== 32'hDEADBEEF || m_wr_strb !== 4'hF) begin
            errors++; $display("FAIL wr_cmd: got %h/%h/%h want 10/deadbeef/f", m_wr_addr, m_wr_data, m_wr_strb);
        end
        checks++;
        if (s_wr_wait !== 2'b01 || s_rd_wait !== 2'b00) begin
            errors++; $display("FAIL wr_wait_fwd: got wr=%b rd=%b want 01 00", s_wr_wait, s_rd_wait);
        end
        tick();
        m_wr_wait = 1'b0;
        m_wr_ack  = 1'b1;
        checks++;
        if (s_wr_ack !== 2'b00) begin
            errors++; $display("FAIL wr_ack_early: got %b want 00", s_wr_ack);
        end
        tick();
        m_wr_ack = 1'b0;
        checks++;
        if (s_wr_ack !== 2'b01 || m_wr_en !== 1'b0) begin
            errors++; $display("FAIL wr_ack_pulse: got ack=%b en=%b want 01 0", s_wr_ack, m_wr_en);
        end
        s_wr_en = 2'b00;
        tick();
        checks++;
        if (s_wr_ack !== 2'b00) begin
            errors++; $display("FAIL wr_ack_once: got %b want 00", s_wr_ack);
        end
    endtask

    task automatic test_contention();
        bit           ok;
        int unsigned  id;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [N-1:0]  exp_ack;
        s_rd_addr[0 +: AW]  = 40'h100;
        s_rd_addr[AW +: AW] = 40'h200;
        s_rd_en = 2'b11;
        for (int k = 0; k < 4; k++) begin
            id       = 32'(k % 2);
            exp_addr = (id == 1) ? 40'h200 : 40'h100;
            exp_data = (id == 1) ? 32'h22222222 : 32'h11111111;
            exp_ack  = (id == 1) ? 2'b10 : 2'b01;
            wait_rd_en(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rr_grant_timeout[%0d]: got m_rd_en=0 want 1", k);
            end
            checks++;
            if (m_rd_addr !== exp_addr) begin
                errors++; $display("FAIL rr_addr[%0d]: got %h want %h", k, m_rd_addr, exp_addr);
            end
            m_rd_data = exp_data;
            m_rd_ack  = 1'b1;
            tick();
            m_rd_ack  = 1'b0;
            m_rd_data = 32'hBADBAD00;
            checks++;
            if (s_rd_ack !== exp_ack || s_rd_data !== exp_data) begin
                errors++; $display("FAIL rr_ack[%0d]: got ack=%b data=%h want %b %h", k, s_rd_ack, s_rd_data, exp_ack, exp_data);
            end
            if (k == 3) s_rd_en = 2'b00;
        end
        tick();
        checks++;
        if (s_rd_ack !== 2'b00 || s_rd_data !== '0) begin
            errors++; $display("FAIL rd_data_clear: got ack=%b data=%h want 00 0", s_rd_ack, s_rd_data);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        s_rd_addr[0 +: AW] = 40'h300;
        s_rd_en   = 2'b01;
        m_rd_data = 32'hCAFEF00D;
        wait_rd_en(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tmo_start: got m_rd_en=0 want 1");
        end
        n = 0;
        while (m_rd_en && n < 30) begin tick(); n++; end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL tmo_cycles: got %0d want 8", n);
        end
        checks++;
        if (s_rd_ack !== 2'b01 || s_rd_data !== '0) begin
            errors++; $display("FAIL tmo_ack: got ack=%b data=%h want 01 0", s_rd_ack, s_rd_data);
        end
        s_rd_en  = 2'b00;
        m_rd_ack = 1'b1;
        tick();
        m_rd_ack = 1'b0;
        tick();
        checks++;
        if (s_rd_ack !== 2'b00 || m_rd_en !== 1'b0) begin
            errors++; $display("FAIL tmo_late_ack: got ack=%b en=%b want 00 0", s_rd_ack, m_rd_en);
        end

        s_rd_addr[AW +: AW] = 40'h400;
        s_rd_en   = 2'b10;
        m_rd_wait = 1'b1;
        wait_rd_en(ok);
        checks++;
        if (!ok || s_rd_wait !== 2'b10) begin
            errors++; $display("FAIL wait_fwd: got en=%b wait=%b want 1 10", m_rd_en, s_rd_wait);
        end
        n = 0;
        repeat (20) begin tick(); if (m_rd_en) n++; end
        checks++;
        if (n != 20) begin
            errors++; $display("FAIL wait_hold: got %0d want 20", n);
        end
        m_rd_wait = 1'b0;
        m_rd_data = 32'h5A5A5A5A;
        m_rd_ack  = 1'b1;
        tick();
        m_rd_ack  = 1'b0;
        checks++;
        if (s_rd_ack !== 2'b10 || s_rd_data !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL wait_ack: got ack=%b data=%h want 10 5a5a5a5a", s_rd_ack, s_rd_data);
        end
        s_rd_en = 2'b00;
        tick();
    endtask

    task automatic test_concurrent();
        s_wr_addr[AW +: AW] = 40'h20;
        s_wr_data[DW +: DW] = 32'h12345678;
        s_wr_strb[SW +: SW] = 4'h3;
        s_wr_en = 2'b10;
        s_rd_addr[0 +: AW] = 40'h30;
        s_rd_en = 2'b01;
        tick();
        checks++;
        if (m_wr_en !== 1'b1 || m_rd_en !== 1'b1) begin
            errors++; $display("FAIL conc_en: got wr=%b rd=%b want 1 1", m_wr_en, m_rd_en);
        end
        checks++;
        if (m_wr_addr !== 40'h20 || m_wr_data !== 32'h12345678 || m_wr_strb !== 4'h3 || m_rd_addr !== 40'h30) begin
            errors++; $display("FAIL conc_cmd: got %h/%h/%h rd %h want 20/12345678/3 rd 30",
                               m_wr_addr, m_wr_data, m_wr_strb, m_rd_addr);
        end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        checks++;
        if (s_wr_ack !== 2'b10 || s_rd_ack !== 2'b00 || m_rd_en !== 1'b1) begin
            errors++; $display("FAIL conc_wr_ack: got wr=%b rd=%b rd_en=%b want 10 00 1", s_wr_ack, s_rd_ack, m_rd_en);
        end
        s_wr_en   = 2'b00;
        m_rd_data = 32'h00000077;
        m_rd_ack  = 1'b1;
        tick();
        m_rd_ack  = 1'b0;
        checks++;
        if (s_rd_ack !== 2'b01 || s_rd_data !== 32'h77 || s_wr_ack !== 2'b00) begin
            errors++; $display("FAIL conc_rd_ack: got rd=%b data=%h wr=%b want 01 77 00", s_rd_ack, s_rd_data, s_wr_ack);
        end
        s_rd_en = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        s_wr_addr[0 +: AW] = 40'h40;
        s_wr_en   = 2'b01;
        m_wr_wait = 1'b1;
        tick();
        checks++;
        if (m_wr_en !== 1'b1 || s_wr_wait !== 2'b01) begin
            errors++; $display("FAIL mid_busy: got en=%b wait=%b want 1 01", m_wr_en, s_wr_wait);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (m_wr_en !== 1'b0 || s_wr_wait !== 2'b00 || m_wr_addr !== '0 || s_wr_ack !== 2'b00) begin
            errors++; $display("FAIL mid_reset: got en=%b wait=%b addr=%h ack=%b want 0 00 0 00",
                               m_wr_en, s_wr_wait, m_wr_addr, s_wr_ack);
        end
        s_wr_en   = 2'b00;
        m_wr_wait = 1'b0;
        tick();
        rstn     = 1'b1;
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        tick();
        checks++;
        if (s_wr_ack !== 2'b00 || m_wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_late_ack: got ack=%b en=%b want 00 0", s_wr_ack, m_wr_en);
        end
        s_wr_addr[0 +: AW]  = 40'h50;
        s_wr_addr[AW +: AW] = 40'h60;
        s_wr_en = 2'b11;
        tick();
        checks++;
        if (m_wr_en !== 1'b1 || m_wr_addr !== 40'h50) begin
            errors++; $display("FAIL mid_first_grant: got en=%b addr=%h want 1 50", m_wr_en, m_wr_addr);
        end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        s_wr_en  = 2'b00;
        checks++;
        if (s_wr_ack !== 2'b01) begin
            errors++; $display("FAIL mid_first_ack: got %b want 01", s_wr_ack);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int unsigned c0;
        int unsigned c1;
        s_wr_addr[0 +: AW] = 40'h70;
        s_wr_en = 2'b01;
        wait_wr_en(ok);
        c0 = cyc;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_first: got m_wr_en=0 want 1");
        end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        checks++;
        if (s_wr_ack !== 2'b01) begin
            errors++; $display("FAIL b2b_ack1: got %b want 01", s_wr_ack);
        end
        s_wr_en = 2'b00;
        tick();
        s_wr_addr[0 +: AW] = 40'h74;
        s_wr_en = 2'b01;
        tick();
        c1 = cyc;
        checks++;
        if (m_wr_en !== 1'b1 || m_wr_addr !== 40'h74) begin
            errors++; $display("FAIL b2b_regrant: got en=%b addr=%h want 1 74", m_wr_en, m_wr_addr);
        end
        checks++;
        if (c1 - c0 != 3) begin
            errors++; $display("FAIL b2b_gap: got %0d want 3", c1 - c0);
        end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        checks++;
        if (s_wr_ack !== 2'b01) begin
            errors++; $display("FAIL b2b_ack2: got %b want 01", s_wr_ack);
        end
        s_wr_en = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_timeout();
        test_concurrent();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axilite_reg_arb.md
Name: axilite_reg_arb

Overview:
- Round-robin arbiter that shares one register-interface target between N_REQ register-interface requesters.
- Typical requesters: the host AXI-lite bridge and internal sequencers/DMA descriptor engines.
- The write and read channels are arbitrated independently.
- Adds one registered stage in each direction and has an optional per-transaction timeout, so a hung target cannot lock up a requester.

Parameters:
N_REQ, 2, number of requesters (>=2)
DATA_WR_WIDTH, 32, write data width
DATA_RD_WIDTH, 32, read data width
ADDR_WIDTH, 40, address width
STRB_WIDTH, 4, write strobe width (DATA_WR_WIDTH/8)
TIMEOUT, 0, cycles to wait for target ack before self-acking; 0 = disabled

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_wr_addr  in  N_REQ*ADDR_WIDTH  packed requester write addresses
s_wr_data  in  N_REQ*DATA_WR_WIDTH  packed write data
s_wr_strb  in  N_REQ*STRB_WIDTH  packed write strobes
s_wr_en  in  N_REQ  write request, held high until own ack
s_wr_wait  out  N_REQ  target wait, forwarded to granted requester only
s_wr_ack  out  N_REQ  one-cycle write completion
s_rd_addr  in  N_REQ*ADDR_WIDTH  packed read addresses
s_rd_en  in  N_REQ  read request, held until own ack
s_rd_data  out  DATA_RD_WIDTH  shared read data, valid only with s_rd_ack bit
s_rd_wait  out  N_REQ  forwarded target read wait
s_rd_ack  out  N_REQ  one-cycle read completion
m_wr_addr/m_wr_data/m_wr_strb  out  ADDR/DATA_WR/STRB  target write command
m_wr_en  out  1  target write enable, held until m_wr_ack
m_wr_wait  in  1  target extends write (suspends timeout)
m_wr_ack  in  1  target write done
m_rd_addr  out  ADDR_WIDTH  target read address
m_rd_en  out  1  target read enable
m_rd_data  in  DATA_RD_WIDTH  target read data, sampled on m_rd_ack
m_rd_wait  in  1  target extends read
m_rd_ack  in  1  target read done

Behaviour:
- Reset (rstn low, asynchronous): every output is 0, both FSMs go to IDLE, RR pointers = N_REQ-1 (requester 0 wins first), timeout counters = 0. A target transaction in flight is abandoned; any late m_*_ack arriving in IDLE is ignored.
- Per-channel FSM, IDLE -> BUSY -> ACK -> IDLE:
- IDLE:
  - If any en bit is high, grant the first requester after the pointer, searching upward with wrap.
  - Capture its addr/data/strb into registers.
  - Set m_*_en=1 on the next edge (request-to-target latency 1 cycle), update the pointer to the grant, go to BUSY.
- BUSY:
  - m_*_en and the command are held stable.
  - s_*_wait[gnt] = m_*_wait, combinational. All other wait bits are 0.
  - On m_*_ack: clear m_*_en, latch m_rd_data (read channel), go to ACK.
  - Timeout (TIMEOUT>0): the counter increments each BUSY cycle while m_*_wait=0 and holds while wait=1. When it reaches TIMEOUT, clear m_*_en, load rd data = 0, go to ACK. A target ack arriving after the timeout is dropped.
- ACK:
  - s_*_ack[gnt]=1 for exactly one cycle; s_rd_data holds the latched data that cycle (0 otherwise).
  - Next state IDLE; the requester must drop en at that edge.
  - IDLE samples new requests the following cycle, giving a minimum of 3 cycles between grants on one channel.
- Ack from target to requester takes 1 cycle (ack registered).
- Target ack arriving on the same cycle m_*_en first rises: accepted.
- A requester dropping en while BUSY: the transaction still completes and the ack is still pulsed.
- Requests arriving while BUSY/ACK wait; there is no queueing beyond the held en.
- Write and read channels are fully independent. Simultaneous write and read to the same address both issue; ordering is the target's responsibility.
- Only one bit of s_*_ack is ever high per channel.

Decomposition:
- Package axilite_reg_arb_pkg holds:
  - FSM state enum (IDLE, BUSY, ACK);
  - round-robin next-grant function (pointer, request vector -> index);
  - timeout counter width constant, $clog2(TIMEOUT+1).
- Sub-module axilite_reg_arb_chan is a generic single-channel arbiter (command width parameterised, optional return-data width). It is instantiated once for write (payload addr+data+strb, no return data) and once for read (payload addr, return data).

Test Plan:
- Single write: req0 wr addr=0x10, data=0xDEADBEEF, strb=0xF; target acks 2 cycles after m_wr_en -> m_wr_* match; s_wr_ack[0] pulses once, 1 cycle after m_wr_ack.
- Contention: req0 and req1 both assert rd_en continuously -> grants alternate 0,1,0,1; each read returns the target's m_rd_data (0x11111111, 0x22222222) on the correct ack bit.
- Timeout: TIMEOUT=8, target never acks -> m_rd_en drops after 8 BUSY cycles; s_rd_ack pulses with s_rd_data=0. With m_rd_wait held high for 20 cycles and then an ack, no timeout fires and the data passes through.
- Concurrent channels: req1 write and req0 read issued on the same cycle -> both m_wr_en and m_rd_en rise on the next cycle; both acks are returned independently.
- Reset mid-operation: rstn pulled low during BUSY -> all outputs 0 immediately. After release, a late m_wr_ack is ignored and the first new grant goes to req0.
- Back-to-back from one requester: req0 re-asserts wr_en right after its ack while req1 is idle -> the next grant goes to req0 again; the gap between m_wr_en rises is 3 cycles.
